// File: rtl/hazard_scoreboard.sv
// Data-hazard unit for the in-order pipeline: a shift scoreboard of in-flight
// destinations drives operand forwarding selects and load-use bubbles for ID.
module hazard_scoreboard #(
  parameter  int REG_ADDR_W = 5,
  parameter  int DEPTH      = 3,
  parameter  int LOAD_READY = 1,
  parameter  int CNT_W      = 16,
  localparam int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                                  CLK,
  input  logic                                  rst_n,
  input  logic                                  id_valid,
  input  logic [REG_ADDR_W-1:0]                 id_rs,
  input  logic [REG_ADDR_W-1:0]                 id_rt,
  input  logic                                  id_rs_used,
  input  logic                                  id_rt_used,
  input  logic [REG_ADDR_W-1:0]                 id_rd,
  input  logic                                  id_wen,
  input  logic                                  id_is_load,
  input  logic                                  flush,
  input  logic                                  stall_ext,
  output logic                                  bubble,
  output logic [SEL_W-1:0]                      fwd_rs_sel,
  output logic [SEL_W-1:0]                      fwd_rt_sel,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]      stage_rd,
  output logic [DEPTH-1:0]                      stage_wen,
  output logic [CNT_W-1:0]                      bubble_cnt
);

  typedef struct packed {
    logic                  valid;
    logic                  wen;
    logic [REG_ADDR_W-1:0] rd;
    logic                  is_load;
  } entry_t;

  entry_t                r_sb [DEPTH];
  logic [CNT_W-1:0]      r_bubble_cnt;
  logic [DEPTH-1:0]      w_live;
  logic [SEL_W-1:0]      w_rs_sel;
  logic [SEL_W-1:0]      w_rt_sel;
  logic                  w_rs_haz;
  logic                  w_rt_haz;
  logic                  w_bubble;
  logic                  w_issue;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    w_live   = '0;
    stage_rd = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_live[k] = r_sb[k].valid & r_sb[k].wen;
      if (w_live[k]) stage_rd[k] = r_sb[k].rd;
    end
  end

  // Walk from oldest to youngest so the youngest matching stage overrides.
  always_comb begin
    w_rs_sel = '0;
    w_rt_sel = '0;
    w_rs_haz = 1'b0;
    w_rt_haz = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_live[k] && id_rs_used && (id_rs != '0) && (r_sb[k].rd == id_rs)) begin
        w_rs_sel = SEL_W'(k + 1);
        w_rs_haz = r_sb[k].is_load && (k < LOAD_READY);
      end
      if (w_live[k] && id_rt_used && (id_rt != '0) && (r_sb[k].rd == id_rt)) begin
        w_rt_sel = SEL_W'(k + 1);
        w_rt_haz = r_sb[k].is_load && (k < LOAD_READY);
      end
    end
  end

  assign w_bubble = id_valid & ~flush & (w_rs_haz | w_rt_haz);
  assign w_issue  = id_valid & ~flush & ~w_bubble;

  // NOTE: the scoreboard is reset in full; stale valid bits would raise phantom hazards after reset.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_sb[k] <= '0;
    end else if (!stall_ext) begin
      // NOTE: non-blocking assignments let every stage shift from the pre-edge values at once.
      for (int k = 1; k < DEPTH; k++) r_sb[k] <= r_sb[k-1];
      if (w_issue) begin
        r_sb[0] <= '{valid: 1'b1, wen: id_wen, rd: id_rd, is_load: id_is_load};
      end else begin
        r_sb[0] <= '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && !stall_ext && (r_bubble_cnt != '1)) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign bubble     = w_bubble;
  assign fwd_rs_sel = w_rs_sel;
  assign fwd_rt_sel = w_rt_sel;
  assign stage_wen  = w_live;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised data-hazard unit for the in-order pipeline.
- Tracks the destination register of every in-flight instruction in a shift scoreboard of DEPTH downstream stages (default EX/MA/WB).
- Produces per-operand forwarding selects and a load-use bubble for the instruction currently in ID.
- Adds external freeze, branch flush, configurable load-ready stage and a bubble performance counter.

Parameters:
- REG_ADDR_W, 5, register-address width; address 0 is hard-wired zero and never hazards.
- DEPTH, 3, number of tracked stages after ID; index 0 = EX, 1 = MA, 2 = WB.
- LOAD_READY, 1, lowest stage index whose output carries load data; a load in any index below this forces a bubble. Legal range 0..DEPTH-1.
- CNT_W, 16, bubble counter width.
- SEL_W, $clog2(DEPTH+1), forwarding-select width (derived, not overridden).

Ports:
- CLK  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID holds a real instruction.
- id_rs  input  REG_ADDR_W  source operand A address.
- id_rt  input  REG_ADDR_W  source operand B address.
- id_rs_used  input  1  operand A is read.
- id_rt_used  input  1  operand B is read.
- id_rd  input  REG_ADDR_W  destination address.
- id_wen  input  1  instruction writes id_rd.
- id_is_load  input  1  instruction is a load.
- flush  input  1  kill the ID instruction (taken branch/jump).
- stall_ext  input  1  freeze whole pipeline (memory wait).
- bubble  output  1  load-use hazard: hold IF/ID, insert NOP into EX.
- fwd_rs_sel  output  SEL_W  0 = register file, k+1 = forward from stage k.
- fwd_rt_sel  output  SEL_W  same encoding for operand B.
- stage_rd  output  [DEPTH-1:0][REG_ADDR_W-1:0]  destination per stage, 0 when entry invalid or not writing.
- stage_wen  output  DEPTH  write-enable per stage.
- bubble_cnt  output  CNT_W  saturating count of bubble cycles.

Behaviour:
- Scoreboard entry k holds {valid, wen, rd, is_load}.
- Reset (async, rst_n low): all entries cleared, bubble_cnt = 0. Outputs are combinational from state and inputs, so with id_valid low: bubble = 0, selects = 0, stage_rd = 0, stage_wen = 0.
- Hit on source s (s != 0, its _used bit high): some entry k with valid & wen & rd == s. The lowest (youngest) k wins.
- No hit: sel = 0. Hit at k: sel = k+1.
- A hit at k < LOAD_READY with is_load = 1 is a load-use hazard.
- bubble = id_valid & !flush & (hazard on rs | hazard on rt).
- Selects are computed even when bubble = 1, and are don't-care then.
- Update on a rising edge with stall_ext = 0:
  - entry[k] <= entry[k-1] for k = 1..DEPTH-1; entry[DEPTH-1] retires.
  - entry[0] <= ID instruction if id_valid & !flush & !bubble, else cleared.
- With stall_ext = 1: no entry changes and bubble_cnt holds. Outputs keep being recomputed combinationally.
- Flush and hazard in the same cycle: flush wins, so bubble = 0 and entry[0] is cleared.
- Older entries are never killed by flush.
- bubble_cnt increments on each edge where bubble = 1 and stall_ext = 0, saturating at all-ones.
- Multi-cycle stall: a load at index j < LOAD_READY produces a bubble on consecutive cycles until it reaches index LOAD_READY. It then forwards with sel = LOAD_READY+1.
- An instruction in ID that writes its own source does not self-hit; only the scoreboard is compared.

Test Plan:
- Reset mid-run: fill entries with rd = 3,4,5, assert rst_n = 0 asynchronously → stage_wen = 000 and stage_rd all 0 immediately; bubble_cnt = 0.
- ALU chain: add r3 then sub using rs = r3 next cycle → fwd_rs_sel = 1, bubble = 0. One cycle later (r3 now in MA) → fwd_rs_sel = 2.
- Load-use: lw r5 followed by add rt = r5 → bubble = 1 for one cycle, EX gets a NOP. Next cycle: bubble = 0, fwd_rt_sel = 2, bubble_cnt = 1.
- Priority: entries EX rd = 7 and MA rd = 7, ID rs = 7 → fwd_rs_sel = 1. Same with rs = r0 and entries rd = 0 with wen → fwd_rs_sel = 0, no bubble.
- Freeze/flush: load-use hazard with stall_ext = 1 for 3 cycles → scoreboard unchanged, bubble_cnt unchanged. Same hazard with flush = 1 → bubble = 0 and entry[0] cleared on the next edge.
- Parametrisation: DEPTH = 4, LOAD_READY = 2 → lw followed by dependent instruction gives 2 bubble cycles, then fwd sel = 3. bubble_cnt saturates at 0xFFFF under a forced continuous hazard.
